// File: rtl/mapped_combiner_fifo_pkg.sv
// rtl/mapped_combiner_fifo_pkg.sv - address map and combine-mode encoding for mapped_combiner_fifo
package mapped_combiner_pkg;

    localparam logic [2:0] WR_MODE = 3'd6;
    localparam logic [2:0] WR_CLR  = 3'd7;

    localparam logic [2:0] RD_STATUS = 3'd0;
    localparam logic [2:0] RD_Y      = 3'd1;
    localparam logic [2:0] RD_YCNT   = 3'd2;
    localparam logic [2:0] RD_MODE   = 3'd3;
    localparam logic [2:0] RD_CNT    = 3'd4;

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2,
        OP_ADD = 2'd3
    } op_e;

endpackage

// File: rtl/mapped_combiner_fifo_sync_fifo.sv
// rtl/mapped_combiner_fifo_sync_fifo.sv - circular-buffer FIFO with occupancy count, no bypass
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Head is read straight from storage, so a fresh write only shows once count moves
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mapped_combiner_fifo.sv
// rtl/mapped_combiner_fifo.sv - NUM_CH input FIFOs combined by a selectable op into output FIFO Y
module mapped_combiner_fifo
    import mapped_combiner_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 4,
    parameter int Y_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [2:0]        write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    output logic              write_rdy,
    input  logic [2:0]        read_address,
    input  logic              read_en,
    output logic [DATA_W-1:0] read_data,
    output logic              read_rdy,
    output logic [DATA_W-1:0] counter_out,
    output logic [NUM_CH-1:0] in_ff_empty_n,
    output logic              y_ff_empty_n
);

    localparam int ICW = $clog2(DEPTH) + 1;
    localparam int YCW = $clog2(Y_DEPTH) + 1;

    logic [NUM_CH-1:0]             in_push;
    logic [NUM_CH-1:0]             in_full;
    logic [NUM_CH-1:0]             in_empty;
    logic [NUM_CH-1:0][DATA_W-1:0] in_head;
    logic [ICW-1:0]                in_count [NUM_CH];

    logic [DATA_W-1:0] y_head;
    logic [YCW-1:0]    y_count;
    logic              y_full;
    logic              y_empty;
    logic              y_pop;

    op_e               mode;
    logic [DATA_W-1:0] counter;
    logic [DATA_W-1:0] comb_res;
    logic              fire;
    logic              wr_rdy_raw;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_data;
    logic              rd_rdy;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_in
        sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
            .clk       (CLK),
            .rst       (RST),
            .push      (in_push[c]),
            .push_data (write_data),
            .pop       (fire),
            .pop_data  (in_head[c]),
            .count     (in_count[c])
        );
        assign in_full[c]  = (in_count[c] == ICW'(DEPTH));
        assign in_empty[c] = (in_count[c] == '0);
    end

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(Y_DEPTH)) u_y_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (fire),
        .push_data (comb_res),
        .pop       (y_pop),
        .pop_data  (y_head),
        .count     (y_count)
    );

    assign y_full  = (y_count == YCW'(Y_DEPTH));
    assign y_empty = (y_count == '0);
    // Both conditions come from registered counts, so a same-cycle pop of Y never unblocks
    assign fire    = (&(~in_empty)) && !y_full;

    always_comb begin
        wr_rdy_raw = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (write_address == 3'(c)) begin
                wr_rdy_raw = !in_full[c];
            end
        end
    end

    assign write_rdy = !RST && wr_rdy_raw;
    assign wr_ok     = write_en && write_rdy;

    always_comb begin
        in_push = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_push[c] = wr_ok && (write_address == 3'(c));
        end
    end

    always_comb begin
        comb_res = in_head[0];
        for (int c = 1; c < NUM_CH; c++) begin
            case (mode)
                OP_OR:   comb_res = comb_res | in_head[c];
                OP_AND:  comb_res = comb_res & in_head[c];
                OP_XOR:  comb_res = comb_res ^ in_head[c];
                default: comb_res = comb_res + in_head[c];
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode    <= OP_OR;
            counter <= '0;
        end else begin
            if (wr_ok && write_address == WR_MODE) begin
                mode <= op_e'(write_data[1:0]);
            end
            if (wr_ok && write_address == WR_CLR) begin
                counter <= '0;
            end else if (fire) begin
                counter <= counter + 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_rdy  = 1'b1;
        case (read_address)
            RD_STATUS: rd_data = DATA_W'({~in_full, ~y_empty});
            RD_Y: begin
                rd_data = y_head;
                rd_rdy  = !y_empty;
            end
            RD_YCNT:   rd_data = DATA_W'(y_count);
            RD_MODE:   rd_data = DATA_W'(mode);
            RD_CNT:    rd_data = counter;
            default:   rd_data = '0;
        endcase
    end

    assign read_rdy      = !RST && rd_rdy;
    assign read_data     = RST ? '0 : rd_data;
    assign y_pop         = read_en && read_rdy && (read_address == RD_Y);
    assign counter_out   = counter;
    assign in_ff_empty_n = RST ? '0 : ~in_empty;
    assign y_ff_empty_n  = !RST && !y_empty;

endmodule

// File: tb/tb_mapped_combiner_fifo.sv
// tb/tb_mapped_combiner_fifo.sv - directed self-checking bench for mapped_combiner_fifo
module tb_mapped_combiner_fifo;

    logic       CLK;
    logic       RST;
    logic [2:0] write_address;
    logic [7:0] write_data;
    logic       write_en;
    logic       write_rdy;
    logic [2:0] read_address;
    logic       read_en;
    logic [7:0] read_data;
    logic       read_rdy;
    logic [7:0] counter_out;
    logic [1:0] in_ff_empty_n;
    logic       y_ff_empty_n;

    int n_checks;
    int n_passed;

    mapped_combiner_fifo #(.DATA_W(8), .NUM_CH(2), .DEPTH(4), .Y_DEPTH(4)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy),
        .counter_out   (counter_out),
        .in_ff_empty_n (in_ff_empty_n),
        .y_ff_empty_n  (y_ff_empty_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        write_address = a;
        write_data    = d;
        write_en      = 1'b1;
        tick();
        write_en      = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
        read_en      = 1'b0;
        read_address = a;
        #1;
        check(tag, read_data, exp);
    endtask

    task automatic pop_y(input string tag, input logic [7:0] exp);
        read_address = 3'd1;
        #1;
        check({tag, "_rdy"}, read_rdy, 1'b1);
        check(tag, read_data, exp);
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_passed      = 0;
        RST           = 1'b1;
        write_address = 3'd0;
        write_data    = 8'h00;
        write_en      = 1'b0;
        read_address  = 3'd0;
        read_en       = 1'b0;
        tick();
        tick();

        check("rst_write_rdy", write_rdy, 1'b0);
        check("rst_read_rdy", read_rdy, 1'b0);
        check("rst_read_data", read_data, 8'h00);
        check("rst_in_empty_n", in_ff_empty_n, 2'b00);
        check("rst_y_empty_n", y_ff_empty_n, 1'b0);
        check("rst_counter", counter_out, 8'h00);
        RST = 1'b0;
        #1;
        check("post_rst_write_rdy", write_rdy, 1'b1);

        // OR of complementary nibbles, one-cycle combine latency
        wr(3'd6, 8'h00);
        wr(3'd0, 8'h0F);
        wr(3'd1, 8'hF0);
        check("no_bypass_y", y_ff_empty_n, 1'b0);
        tick();
        check("t1_y_empty_n", y_ff_empty_n, 1'b1);
        check("t1_counter", counter_out, 8'h01);
        pop_y("t1_or", 8'hFF);
        check("t1_y_drained", y_ff_empty_n, 1'b0);

        wr(3'd6, 8'h03);
        wr(3'd0, 8'hF0);
        wr(3'd1, 8'h20);
        tick();
        pop_y("t2_add_wrap", 8'h10);
        wr(3'd6, 8'h01);
        wr(3'd0, 8'hCC);
        wr(3'd1, 8'hAA);
        tick();
        pop_y("t2_and", 8'h88);
        wr(3'd6, 8'h02);
        wr(3'd0, 8'hCC);
        wr(3'd1, 8'hAA);
        tick();
        pop_y("t2_xor", 8'h66);
        check("t2_counter", counter_out, 8'h04);
        rd_check("t2_mode", 3'd3, 8'h02);

        // Overfill ch0 with ch1 idle: fifth write is refused
        for (int i = 0; i < 5; i++) begin
            write_address = 3'd0;
            write_data    = 8'(i + 1);
            #1;
            check($sformatf("t3_wr_rdy_%0d", i), write_rdy, (i < 4) ? 1'b1 : 1'b0);
            write_en = 1'b1;
            tick();
            write_en = 1'b0;
        end
        check("t3_in_empty_n", in_ff_empty_n, 2'b01);
        rd_check("t3_status", 3'd0, 8'h04);
        check("t3_counter", counter_out, 8'h04);
        for (int i = 0; i < 4; i++) begin
            wr(3'd1, 8'(8'h10 * (i + 1)));
        end
        tick();
        tick();
        rd_check("t3_ycnt", 3'd2, 8'h04);
        check("t3_counter_after", counter_out, 8'h08);
        pop_y("t3_xor0", 8'h11);
        pop_y("t3_xor1", 8'h22);
        pop_y("t3_xor2", 8'h33);
        pop_y("t3_xor3", 8'h44);
        check("t3_in_drained", in_ff_empty_n, 2'b00);
        check("t3_y_drained", y_ff_empty_n, 1'b0);

        RST = 1'b1;
        tick();
        RST = 1'b0;

        // Eight pairs with Y never read: four combine, four stall in the inputs
        for (int i = 0; i < 8; i++) begin
            wr(3'd0, 8'(i + 1));
            wr(3'd1, 8'h80);
        end
        tick();
        tick();
        rd_check("t4_ycnt_full", 3'd2, 8'h04);
        check("t4_counter", counter_out, 8'h04);
        check("t4_in_empty_n", in_ff_empty_n, 2'b11);
        rd_check("t4_status", 3'd0, 8'h01);
        pop_y("t4_head", 8'h81);
        rd_check("t4_ycnt_after_pop", 3'd2, 8'h03);
        tick();
        rd_check("t4_ycnt_refill", 3'd2, 8'h04);
        check("t4_counter_refill", counter_out, 8'h05);

        // Reset with every FIFO holding data
        wr(3'd6, 8'h03);
        rd_check("t6_mode_pre", 3'd3, 8'h03);
        RST = 1'b1;
        tick();
        check("t6_in_empty_n", in_ff_empty_n, 2'b00);
        check("t6_y_empty_n", y_ff_empty_n, 1'b0);
        check("t6_counter", counter_out, 8'h00);
        check("t6_read_rdy_held", read_rdy, 1'b0);
        RST = 1'b0;
        rd_check("t6_mode", 3'd3, 8'h00);
        rd_check("t6_ycnt", 3'd2, 8'h00);
        read_address = 3'd1;
        #1;
        check("t6_y_read_rdy", read_rdy, 1'b0);
        check("t6_in_after", in_ff_empty_n, 2'b00);

        // Clear and mode writes colliding with a combine
        wr(3'd0, 8'h01);
        wr(3'd1, 8'h02);
        wr(3'd7, 8'h00);
        check("t5_clr_wins", counter_out, 8'h00);
        check("t5_y_empty_n", y_ff_empty_n, 1'b1);
        wr(3'd0, 8'h0C);
        wr(3'd1, 8'h0A);
        wr(3'd6, 8'h02);
        tick();
        wr(3'd0, 8'h0C);
        wr(3'd1, 8'h0A);
        tick();
        pop_y("t5_first", 8'h03);
        pop_y("t5_old_mode", 8'h0E);
        pop_y("t5_new_mode", 8'h06);
        check("t5_counter", counter_out, 8'h02);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
